// File: rtl/bonsai_pkg.sv
// Shared definitions for the bonsai merge-tree width couplers.
package bonsai_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IN_RECS    = 4;
  // Widest beat the terminator test accepts; narrower beats are zero-extended.
  localparam int unsigned TERM_MAX_W = 1024;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no half-beat held
    HALF  = 2'd1,  // low half held in lo_hold
    FLUSH = 2'd2   // all-zero terminator beat still owed downstream
  } state_t;

  // A beat whose records are all zero marks the end of a sorted stream.
  function automatic logic is_term(input logic [TERM_MAX_W-1:0] beat);
    return (beat == '0);
  endfunction

endpackage

// File: rtl/coupler_4_to_8.sv
// Width coupler: packs pairs of IN_RECS-record beats from a show-ahead FIFO
// into 2*IN_RECS-record beats, earlier beat in the low half, and forwards
// the all-zero terminator so stream boundaries survive the width change.
module coupler_4_to_8
  import bonsai_pkg::state_t;
  import bonsai_pkg::EMPTY;
  import bonsai_pkg::HALF;
  import bonsai_pkg::FLUSH;
  import bonsai_pkg::TERM_MAX_W;
  import bonsai_pkg::is_term;
#(
  parameter int unsigned DATA_W  = bonsai_pkg::DATA_W,
  parameter int unsigned IN_RECS = bonsai_pkg::IN_RECS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [IN_RECS*DATA_W-1:0]     i_fifo,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_read,
  input  logic                          i_fifo_out_ready,
  output logic                          o_out_fifo_write,
  output logic [2*IN_RECS*DATA_W-1:0]   o_data
);

  localparam int unsigned IN_W  = IN_RECS * DATA_W;
  localparam int unsigned OUT_W = 2 * IN_W;

  state_t             r_state;
  state_t             w_state_next;
  logic [IN_W-1:0]    r_lo_hold;
  logic [OUT_W-1:0]   r_data;
  logic               r_write;

  logic               w_head_valid;
  logic               w_term;
  logic [TERM_MAX_W-1:0] w_term_vec;
  logic               w_fifo_read;
  logic               w_lo_load;
  logic               w_write_next;
  logic [OUT_W-1:0]   w_data_next;

  // A stale head of an empty FIFO is never decoded as a terminator.
  assign w_head_valid = !i_fifo_empty;
  assign w_term_vec   = TERM_MAX_W'(i_fifo);
  assign w_term       = w_head_valid && is_term(w_term_vec);

  // State register; reset discards any held half-beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: data beats in EMPTY need no downstream room, everything else does.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: begin
        if (w_head_valid && !w_term) begin
          w_state_next = HALF;
        end
      end
      HALF: begin
        if (w_head_valid && i_fifo_out_ready) begin
          w_state_next = w_term ? FLUSH : EMPTY;
        end
      end
      FLUSH: begin
        if (i_fifo_out_ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Outputs: pop strobe plus the value and strobe to register for next cycle.
  always_comb begin
    w_fifo_read  = 1'b0;
    w_lo_load    = 1'b0;
    w_write_next = 1'b0;
    w_data_next  = r_data;
    case (r_state)
      EMPTY: begin
        if (w_head_valid) begin
          if (!w_term) begin
            w_fifo_read = 1'b1;
            w_lo_load   = 1'b1;
          end else if (i_fifo_out_ready) begin
            w_fifo_read  = 1'b1;
            w_write_next = 1'b1;
            w_data_next  = '0;
          end
        end
      end
      HALF: begin
        if (w_head_valid && i_fifo_out_ready) begin
          w_fifo_read  = 1'b1;
          w_write_next = 1'b1;
          // A terminator closing a half pair pads the high half with zeros;
          // the full terminator beat follows from FLUSH.
          w_data_next  = w_term ? {{IN_W{1'b0}}, r_lo_hold}
                                : {i_fifo, r_lo_hold};
        end
      end
      FLUSH: begin
        if (i_fifo_out_ready) begin
          w_write_next = 1'b1;
          w_data_next  = '0;
        end
      end
      default: begin
        w_fifo_read  = 1'b0;
        w_write_next = 1'b0;
      end
    endcase
  end

  // Half-beat hold register: captures the low half of a pair.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lo_hold <= '0;
    end else if (w_lo_load) begin
      r_lo_hold <= i_fifo;
    end
  end

  // Output register and one-cycle write strobe; data holds between writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_write <= 1'b0;
    end else begin
      r_write <= w_write_next;
      if (w_write_next) begin
        r_data <= w_data_next;
      end
    end
  end

  assign o_fifo_read      = w_fifo_read;
  assign o_out_fifo_write = r_write;
  assign o_data           = r_data;

endmodule

// File: tb/tb_coupler_4_to_8.sv
// Bench: upstream show-ahead FIFO and downstream FIFO occupancy modelled
// around the coupler, with a stream-level pairing model checked every cycle.
module tb_coupler_4_to_8;

  localparam int DW       = 32;
  localparam int NR       = 4;
  localparam int IW       = DW * NR;
  localparam int OW       = 2 * IW;
  localparam int DN_DEPTH = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [IW-1:0] i_fifo = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_read;
  logic          i_fifo_out_ready = 1'b0;
  logic          o_out_fifo_write;
  logic [OW-1:0] o_data;

  always #5 clk = ~clk;

  coupler_4_to_8 #(.DATA_W(DW), .IN_RECS(NR)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_fifo           (i_fifo),
    .i_fifo_empty     (i_fifo_empty),
    .o_fifo_read      (o_fifo_read),
    .i_fifo_out_ready (i_fifo_out_ready),
    .o_out_fifo_write (o_out_fifo_write),
    .o_data           (o_data)
  );

  // Environment and model state
  logic [IW-1:0] up_q[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] wr_log[$];
  int            dn_cnt = 0;
  bit            have_lo = 0;
  logic [IW-1:0] lo = '0;
  bit            flush_owed = 0;
  bit            due = 0;
  bit            stall = 0, rand_stall = 0, drain_all = 1;
  int unsigned   passed = 0, total = 0;

  task automatic chk(input string name, input bit ok, input logic [OW-1:0] act, input logic [OW-1:0] expv);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [IW-1:0] mk4(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  function automatic bit beat_term(input logic [IW-1:0] b);
    return b == '0;
  endfunction

  // Stream rules: pair beats low-then-high; a terminator closes any open pair
  // with a zero high half and is itself forwarded as an all-zero beat.
  task automatic model_feed(input logic [IW-1:0] b);
    if (!have_lo) begin
      if (beat_term(b)) begin
        exp_q.push_back('0); due = 1;
      end else begin
        lo = b; have_lo = 1;
      end
    end else begin
      have_lo = 0; due = 1;
      if (beat_term(b)) begin
        exp_q.push_back({{IW{1'b0}}, lo});
        flush_owed = 1;
      end else begin
        exp_q.push_back({b, lo});
      end
    end
  endtask

  task automatic cycle();
    bit st, rd, w, rdy, exp_pop, hv;
    logic [IW-1:0] head;
    logic [OW-1:0] e;
    @(negedge clk);
    // Outputs registered at the previous edge
    if (due) begin
      chk("write_strobe", o_out_fifo_write == 1'b1, OW'(o_out_fifo_write), OW'(1));
      if (o_out_fifo_write) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("write_data", exp_q.size() > 0 && o_data == e, o_data, e);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else begin
      chk("no_spurious_write", o_out_fifo_write == 1'b0, OW'(o_out_fifo_write), '0);
    end
    if (o_out_fifo_write) wr_log.push_back(o_data);
    due = 0;
    // Drive upstream head (random junk, sometimes zero, when empty)
    i_fifo_empty = (up_q.size() == 0);
    if (up_q.size() > 0) i_fifo = up_q[0];
    else i_fifo = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
    st = stall || (rand_stall && $urandom_range(0, 3) == 0);
    rd = !st && dn_cnt > 0 && (drain_all || $urandom_range(0, 1) == 1);
    w  = o_out_fifo_write;
    i_fifo_out_ready = !st && (dn_cnt + int'(w) - int'(rd) < DN_DEPTH);
    #3;
    rdy = i_fifo_out_ready;
    if (w) chk("no_overrun", dn_cnt - int'(rd) < DN_DEPTH, OW'(dn_cnt), OW'(DN_DEPTH));
    dn_cnt = dn_cnt + int'(w) - int'(rd);
    hv = (up_q.size() > 0);
    head = hv ? up_q[0] : '0;
    exp_pop = hv && !flush_owed && ((!have_lo && !beat_term(head)) || rdy);
    chk("pop", o_fifo_read == exp_pop, OW'(o_fifo_read), OW'(exp_pop));
    if (flush_owed && rdy) begin
      exp_q.push_back('0); due = 1; flush_owed = 0;
    end
    if (o_fifo_read && hv) begin
      void'(up_q.pop_front());
      model_feed(head);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((up_q.size() > 0 || exp_q.size() > 0 || flush_owed || due) && n < budget) begin
      cycle(); n++;
    end
    chk("idle_timeout", n < budget, OW'(n), OW'(budget));
    repeat (2) cycle();
  endtask

  task automatic run_until_popped(input int budget);
    int n = 0;
    while (up_q.size() > 0 && n < budget) begin
      cycle(); n++;
    end
    chk("pop_timeout", n < budget, OW'(n), OW'(budget));
  endtask

  logic [IW-1:0] A, B, C, D, E, F, T;
  int n0;
  logic [IW-1:0] rb;

  initial begin
    A = mk4(1, 3, 5, 7);   B = mk4(9, 11, 13, 15);
    C = mk4(2, 4, 6, 8);   T = '0;
    D = mk4(17, 19, 21, 23); E = mk4(25, 27, 29, 31);
    #1 i_rst = 1'b1;
    #1;
    chk("reset_write", o_out_fifo_write == 1'b0, OW'(o_out_fifo_write), '0);
    chk("reset_data", o_data == '0, o_data, '0);
    #10 i_rst = 1'b0;

    // 1: simple pair
    n0 = wr_log.size();
    up_q.push_back(A); up_q.push_back(B);
    run_idle(50);
    chk("t1_count", wr_log.size() == n0 + 1, OW'(wr_log.size() - n0), OW'(1));
    chk("t1_data", o_data == 256'h0000000f_0000000d_0000000b_00000009_00000007_00000005_00000003_00000001,
        o_data, 256'h0000000f_0000000d_0000000b_00000009_00000007_00000005_00000003_00000001);

    // 2: pair then terminator
    n0 = wr_log.size();
    up_q.push_back(A); up_q.push_back(B); up_q.push_back(T);
    run_idle(50);
    chk("t2_count", wr_log.size() == n0 + 2, OW'(wr_log.size() - n0), OW'(2));
    chk("t2_first", wr_log[n0] == {B, A}, wr_log[n0], {B, A});
    chk("t2_term", o_data == '0, o_data, '0);

    // 3: half pair closed by terminator, then flush
    n0 = wr_log.size();
    up_q.push_back(C); up_q.push_back(T);
    run_idle(50);
    chk("t3_count", wr_log.size() == n0 + 2, OW'(wr_log.size() - n0), OW'(2));
    chk("t3_half", wr_log[n0] == 256'h0_00000008_00000006_00000004_00000002,
        wr_log[n0], 256'h0_00000008_00000006_00000004_00000002);
    chk("t3_flush", wr_log[n0 + 1] == '0, wr_log[n0 + 1], '0);

    // 4: stall in HALF with data waiting
    n0 = wr_log.size();
    up_q.push_back(A);
    run_until_popped(20);
    stall = 1;
    up_q.push_back(B);
    repeat (5) cycle();
    chk("t4_no_write", wr_log.size() == n0, OW'(wr_log.size() - n0), '0);
    chk("t4_no_pop", up_q.size() == 1, OW'(up_q.size()), OW'(1));
    stall = 0;
    run_idle(50);
    chk("t4_count", wr_log.size() == n0 + 1, OW'(wr_log.size() - n0), OW'(1));
    chk("t4_data", o_data == {B, A}, o_data, {B, A});

    // 5: upstream empty between halves
    n0 = wr_log.size();
    up_q.push_back(C);
    run_until_popped(20);
    repeat (3) cycle();
    chk("t5_no_write", wr_log.size() == n0, OW'(wr_log.size() - n0), '0);
    up_q.push_back(B);
    run_idle(50);
    chk("t5_data", o_data == {B, C}, o_data, {B, C});

    // 6: async reset while a half is held
    up_q.push_back(A);
    run_until_popped(20);
    #1 i_rst = 1'b1;
    #1;
    chk("t6_rst_write", o_out_fifo_write == 1'b0, OW'(o_out_fifo_write), '0);
    chk("t6_rst_data", o_data == '0, o_data, '0);
    have_lo = 0; flush_owed = 0; due = 0; exp_q.delete();
    #1 i_rst = 1'b0;
    n0 = wr_log.size();
    up_q.push_back(D); up_q.push_back(E);
    run_idle(50);
    chk("t6_count", wr_log.size() == n0 + 1, OW'(wr_log.size() - n0), OW'(1));
    chk("t6_data", o_data == {E, D}, o_data, {E, D});

    // Random traffic with random downstream drain and stalls
    rand_stall = 1; drain_all = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0 && up_q.size() < 6) begin
        if ($urandom_range(0, 5) == 0) rb = '0;
        else rb = {$urandom, $urandom, $urandom, $urandom | 32'd1};
        up_q.push_back(rb);
      end
      cycle();
    end
    rand_stall = 0; drain_all = 1;
    up_q.push_back(T);
    run_idle(300);
    chk("final_queue_empty", exp_q.size() == 0, OW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
